hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the ID-stage branch/jump forwarding path.
- Tracks which registers have in-flight writes that are not yet forwardable:
  - loads, until their data reaches M;
  - the non-pipelined multiply/divide unit, until its result is ready.
- Generates the ID-stage stall so the forwarding path only ever selects values that exist.
- Sits beside the ID/EX pipeline register and is driven by decode.

Parameters:
MD_LAT, 4, cycles from mul/div issue until its result is forwardable (1..2^CNT_W-1)
CNT_W, 3, width of per-register countdown counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a valid instruction
rs_i  in  5  source register A of ID instruction
rt_i  in  5  source register B of ID instruction
use_rs  in  1  ID instruction reads rs_i (compare, ALU, or address)
use_rt  in  1  ID instruction reads rt_i
dst_i  in  5  destination register of ID instruction
reg_wr_id  in  1  ID instruction writes dst_i
op_class  in  2  0=ALU, 1=LOAD, 2=MULDIV, 3=reserved (treated as ALU)
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
md_busy  out  1  mul/div unit occupied
pending  out  32  bit r set when counter[r] != 0

Behaviour:
- Storage and issue:
  - State: cnt[1..31], each CNT_W bits; register 0 has no counter, and pending[0] is constant 0.
  - Also a md_cnt of CNT_W bits.
  - fire = id_valid && !stall.
- Latency on fire with reg_wr_id && dst_i != 0, cnt[dst_i] is set to:
  - ALU: 0;
  - LOAD: 1;
  - MULDIV: MD_LAT.
- md_cnt:
  - Any fire with op_class=MULDIV sets md_cnt to MD_LAT, whether or not it writes a register (hi/lo style).
  - md_busy = (md_cnt != 0).
- Every cycle, every nonzero counter decrements by 1. On the same edge, a set to the same register takes priority over its decrement.
- Stall conditions. stall = id_valid && (raw || waw || struct), all combinational from current state:
  - raw: (use_rs && rs_i != 0 && cnt[rs_i] != 0) || (use_rt && rt_i != 0 && cnt[rt_i] != 0).
  - waw: reg_wr_id && dst_i != 0 && cnt[dst_i] > new_lat(op_class). This prevents a younger, shorter write from being overtaken.
  - struct: op_class == MULDIV && md_busy.
- Load-use timing: a consumer directly after a load sees cnt = 1 and stalls exactly 1 cycle. It is then served from the M-stage memory-data forward.
- A consumer directly after an ALU producer does not stall; E-stage forwarding covers it.
- While stalled, counters keep decrementing, so the stall self-releases without deadlock.
- id_valid = 0 forces stall = 0 and no state update. This is the flush or bubble case.
- Reset (async, active-low):
  - all cnt and md_cnt clear to 0;
  - stall = 0, md_busy = 0, pending = 0.
- Reset asserted mid-mul/div discards the operation. After release no stall is pending.
- Latency of stall: 0 cycles (combinational). The state effect of a fire is visible the next cycle.

Optional Feature:
- Macro: HAZARD_SB_STATS_EN.
- When defined, the block adds output stall_cycles (32 bits).
  - It counts cycles with stall = 1 and wraps at 2^32.
  - Reset value is 0 on the async active-low reset.
- When undefined, the port and counter are absent; the stall logic is identical.

Decomposition:
- Shared package holds:
  - the op_class encodings (OPC_ALU = 0, OPC_LOAD = 1, OPC_MULDIV = 2);
  - the LAT_ALU = 0 and LAT_LOAD = 1 constants;
  - the register-index width of 5.
- One natural sub-module: sb_counter. This is a single CNT_W down-counter with set-priority load and a nonzero flag, instantiated 31 times plus once for md_cnt.

Test Plan:
- Load r8, then beq r8,r9 next cycle -> stall = 1 for exactly 1 cycle, pending[8] = 1 then 0, then fire.
- ALU write r5, then branch using r5 next cycle -> stall never asserts, pending[5] stays 0.
- MULDIV write r10 (MD_LAT = 4), then consumer of r10 -> stall for 4 consecutive cycles, md_busy high for 4 cycles.
- MULDIV to r3 then ALU write r3 one cycle later -> waw stall until cnt[3] = 0, then fire. A later read of r3 sees no stall.
- Two back-to-back MULDIV with different dsts -> second stalls 4 cycles on struct hazard, independent of registers.
- Reset low during MULDIV with cnt[10] = 3 -> pending = 0, md_busy = 0, stall = 0 immediately. With HAZARD_SB_STATS_EN, stall_cycles = 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and latency constants for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        OPC_ALU    = 2'd0,
        OPC_LOAD   = 2'd1,
        OPC_MULDIV = 2'd2,
        OPC_RSVD   = 2'd3
    } op_class_e;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;

endpackage

// File: rtl/sb_counter.sv
// Single scoreboard down-counter: a load wins over the decrement, and the counter
// holds at zero.
module sb_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [CNT_W-1:0] set_val,
    output logic [CNT_W-1:0] cnt,
    output logic             nz
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (set) begin
            cnt_d = set_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign nz  = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight load and mul/div writes and stalls ID until their results are forwardable.
// Optional stall-cycle statistics counter enabled with `define HAZARD_SB_STATS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] dst_i,
    input  logic             reg_wr_id,
    input  logic [1:0]       op_class,
    output logic             stall,
    output logic             md_busy,
    output logic [31:0]      pending
`ifdef HAZARD_SB_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] LatAluC  = CNT_W'(LAT_ALU);
    localparam logic [CNT_W-1:0] LatLoadC = CNT_W'(LAT_LOAD);
    localparam logic [CNT_W-1:0] LatMdC   = CNT_W'(MD_LAT);

    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      nz;
    logic [CNT_W-1:0] md_cnt;
    logic             md_nz;
    logic [CNT_W-1:0] new_lat;
    logic             is_md;
    logic             raw, waw, struct_haz, fire;

    assign is_md = (op_class_e'(op_class) == OPC_MULDIV);

    // Reserved encoding behaves as a plain ALU write.
    always_comb begin
        new_lat = LatAluC;
        case (op_class_e'(op_class))
            OPC_LOAD:   new_lat = LatLoadC;
            OPC_MULDIV: new_lat = LatMdC;
            default:    new_lat = LatAluC;
        endcase
    end

    assign raw = (use_rs && (rs_i != '0) && nz[rs_i]) ||
                 (use_rt && (rt_i != '0) && nz[rt_i]);
    // A younger, shorter write must not retire before an older one to the same register.
    assign waw        = reg_wr_id && (dst_i != '0) && (cnt[dst_i] > new_lat);
    assign struct_haz = is_md && (md_cnt != '0);

    assign stall = id_valid && (raw || waw || struct_haz);
    assign fire  = id_valid && !stall;

    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .set     (fire && reg_wr_id && (dst_i == REG_W'(r))),
            .set_val (new_lat),
            .cnt     (cnt[r]),
            .nz      (nz[r])
        );
    end

    sb_counter #(
        .CNT_W (CNT_W)
    ) u_md_cnt (
        .clk     (clk),
        .reset   (reset),
        .set     (fire && is_md),
        .set_val (LatMdC),
        .cnt     (md_cnt),
        .nz      (md_nz)
    );

    assign md_busy = md_nz;
    assign pending = nz;

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else if (stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (MD_LAT = 4, CNT_W = 3).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  rs_i, rt_i, dst_i;
    logic        use_rs, use_rt, reg_wr_id;
    logic [1:0]  op_class;
    logic        stall, md_busy;
    logic [31:0] pending;
`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .MD_LAT (4),
        .CNT_W  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .use_rs    (use_rs),
        .use_rt    (use_rt),
        .dst_i     (dst_i),
        .reg_wr_id (reg_wr_id),
        .op_class  (op_class),
        .stall     (stall),
        .md_busy   (md_busy),
        .pending   (pending)
`ifdef HAZARD_SB_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic [4:0]  dst;
        logic        wr;
        logic [1:0]  opc;
        logic        exp_stall;
        logic        exp_busy;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic valid, logic [4:0] rs, logic [4:0] rt,
                                logic urs, logic urt, logic [4:0] dst, logic wr,
                                logic [1:0] opc, logic es, logic eb, logic [31:0] ep);
        vec_t x;
        x.name = n; x.valid = valid; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.dst = dst; x.wr = wr; x.opc = opc;
        x.exp_stall = es; x.exp_busy = eb; x.exp_pend = ep;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        id_valid = x.valid; rs_i = x.rs; rt_i = x.rt; use_rs = x.urs; use_rt = x.urt;
        dst_i = x.dst; reg_wr_id = x.wr; op_class = x.opc;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic es, input logic eb,
                            input logic [31:0] ep);
        chk({nm, ".stall"}, {31'd0, stall}, {31'd0, es});
        chk({nm, ".md_busy"}, {31'd0, md_busy}, {31'd0, eb});
        chk({nm, ".pending"}, pending, ep);
    endtask

    localparam logic [31:0] P3  = 32'h0000_0008;
    localparam logic [31:0] P8  = 32'h0000_0100;
    localparam logic [31:0] P9  = 32'h0000_0200;
    localparam logic [31:0] P10 = 32'h0000_0400;
    localparam logic [31:0] P11 = 32'h0000_0800;
    localparam logic [31:0] P12 = 32'h0000_1000;

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use: one stall cycle, then the branch fires.
        vecs.push_back(idle);
        vecs.push_back(mk("load_r8",    1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0));
        vecs.push_back(mk("beq_r8_stl", 1, 8, 9, 1, 1, 0, 0, 0, 1, 0, P8));
        vecs.push_back(mk("beq_r8_go",  1, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0));
        // ALU producer never stalls its consumer.
        vecs.push_back(mk("alu_r5",     1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        vecs.push_back(mk("br_r5",      1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // Mul/div producer: four stall cycles.
        vecs.push_back(mk("md_r10",     1, 1, 2, 1, 1, 10, 1, 2, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("use_r10_stl", 1, 10, 0, 1, 0, 0, 0, 0, 1, 1, P10));
        vecs.push_back(mk("use_r10_go", 1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // WAW: ALU write behind an outstanding mul/div to the same register.
        vecs.push_back(mk("md_r3",      1, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("alu_r3_waw", 1, 0, 0, 0, 0, 3, 1, 0, 1, 1, P3));
        vecs.push_back(mk("alu_r3_go",  1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk("rd_r3",      1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        // Structural hazard on back-to-back mul/div.
        vecs.push_back(mk("md_r11",     1, 0, 0, 0, 0, 11, 1, 2, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("md_r12_str", 1, 0, 0, 0, 0, 12, 1, 2, 1, 1, P11));
        vecs.push_back(mk("md_r12_go",  1, 0, 0, 0, 0, 12, 1, 2, 0, 0, 0));
        // Bubbles never stall and never update state.
        vecs.push_back(mk("bubble",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, P12));
        vecs.push_back(mk("bub_rd_r12", 0, 12, 0, 1, 0, 0, 0, 0, 0, 1, P12));
        vecs.push_back(mk("bub_md_r13", 0, 0, 0, 0, 0, 13, 1, 2, 0, 1, P12));
        vecs.push_back(mk("drain",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, P12));
        vecs.push_back(mk("drained",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Register zero is never tracked.
        vecs.push_back(mk("load_r0",    1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("rd_r0",      1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // Reserved op class behaves as ALU.
        vecs.push_back(mk("rsv_r6",     1, 0, 0, 0, 0, 6, 1, 3, 0, 0, 0));
        vecs.push_back(mk("rd_r6",      1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // ALU write behind a load to the same register: one WAW cycle.
        vecs.push_back(mk("ld_r9",      1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0));
        vecs.push_back(mk("alu_r9_waw", 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, P9));
        vecs.push_back(mk("alu_r9_go",  1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));
        // Mul/div without a register write still occupies the unit.
        vecs.push_back(mk("md_nowr",    1, 0, 0, 0, 0, 7, 0, 2, 0, 0, 0));
        vecs.push_back(mk("md_nowr_bz", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        reset = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("in_reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk_outs(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_busy, vecs[i].exp_pend);
        end

`ifdef HAZARD_SB_STATS_EN
        @(negedge clk);
        drive(idle);
        #1;
        chk("stall_cycles", stall_cycles, 32'd14);
`endif

        // Let the hi/lo mul/div drain, then reset mid-operation with cnt[10] = 3.
        repeat (3) begin
            @(negedge clk);
            drive(idle);
        end
        @(negedge clk);
        #1;
        chk_outs("md_idle", 0, 0, 0);
        drive(mk("md_r10b", 1, 0, 0, 0, 0, 10, 1, 2, 0, 0, 0));
        @(negedge clk);
        drive(idle);
        @(negedge clk);
        drive(mk("use_r10b", 1, 10, 0, 1, 0, 0, 0, 0, 1, 1, P10));
        #1;
        chk_outs("pre_reset", 1, 1, P10);
        reset = 1'b0;
        #1;
        chk_outs("async_reset", 0, 0, 0);
`ifdef HAZARD_SB_STATS_EN
        chk("stall_cycles_rst", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outs("post_reset", 0, 0, 0);
        @(negedge clk);
        #1;
        chk_outs("post_reset2", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
